match_fsm: RTL and testbench
============================

// Module: match_fsm
// PURPOSE
// - Parametrised two-player "higher number wins" match controller. Successor to the fixed 8-bit,
//   best-of-3 game FSM.
// - Keeps its own scores and resolves ties deterministically. Adds a per-turn entry timeout and
//   a configurable round-result hold time.
// - Sits between the debounced button/switch front end and the score/LED/7-seg display logic.
// PARAMETERS
// NUM_W        8   width of each player's number (unsigned compare)
// WIN_ROUNDS   2   rounds needed to win the match (>=1); SCW = $clog2(WIN_ROUNDS+1)
// TIE_MODE     0   0: tie replays the round, no score; 1: tie awarded to P1
// TIMEOUT_CYC  0   entry timeout in clk cycles; 0 disables; else >=2
// HOLD_CYC     1   cycles each round-result state is held (>=1)
// PORTS
// clk          in   1      clock
// reset_n      in   1      async active-low reset
// mid          in   1      start/advance pulse (1 cycle, debounced upstream)
// p1, p2       in   1      player enter pulses (1 cycle)
// p1_num       in   NUM_W  P1 number, sampled on accepted p1
// p2_num       in   NUM_W  P2 number, sampled on accepted p2
// idle, p1_turn, p2_turn  out 1  state flags
// p1_round, p2_round, tie_round  out 1  round-result flags, high for HOLD_CYC cycles
// p1_game, p2_game, clear_st     out 1  end-of-match / clear flags
// timeout      out  1      1-cycle pulse when an entry turn expires
// p1_score, p2_score  out SCW  rounds won
// p1_lat, p2_lat      out NUM_W  latched numbers of the current/last round
// BEHAVIOUR
// - Async reset: state IDLE; scores, latches and counters = 0; only idle = 1.
// - All flags are registered decodes of state_reg; exactly one state flag is high per cycle.
// - IDLE    : mid -> P1_ENT.
// - P1_ENT  : p1 -> latch p1_num, go P2_ENT. p2 and mid ignored.
// - P2_ENT  : p2 -> latch p2_num, go CMP. p1 and mid ignored.
// - CMP     : one cycle.
//   - p1_lat > p2_lat -> P1_RND, p1_score++.
//   - p1_lat < p2_lat -> P2_RND, p2_score++.
//   - Equal -> TIE_RND (TIE_MODE 0), or P1_RND with p1_score++ (TIE_MODE 1). Never stalls.
//   - Latency from accepted p2 to result flag = 2 cycles.
// - P1_RND/P2_RND/TIE_RND: hold HOLD_CYC cycles, then:
//   - winner score == WIN_ROUNDS -> P1_GAME/P2_GAME.
//   - Otherwise -> P1_ENT. TIE_RND always -> P1_ENT.
// - Timeout (TIMEOUT_CYC != 0): counter clears on entry to P1_ENT/P2_ENT.
//   - Reaching TIMEOUT_CYC with no press forfeits the turn: timeout pulses, the opponent's
//     score++, and state goes to their _RND state. Latch is unchanged.
//   - A press in the expiry cycle wins over the timeout.
// - P1_GAME/P2_GAME: scores frozen; mid -> CLEAR.
// - CLEAR   : scores and latches zeroed on entry; mid -> IDLE.
// - Scores saturate at WIN_ROUNDS and never wrap.
// - Unreachable state encodings -> IDLE next cycle.
// - Reset asserted mid-operation aborts immediately. No partial score survives.
// STRUCTURE
// - game_pkg.vh (shared include): state encodings S_IDLE..S_CLEAR, TIE_REPLAY/TIE_P1 constants.
// - Sub-module game_timer: loadable down-counter with a zero flag. One instance, shared by the
//   HOLD and TIMEOUT countdowns (never active simultaneously).
// - Remaining logic (state register, next-state, scores, latches) lives in match_fsm.
// TESTING
// 1 Defaults: mid; p1=0x50; p2=0x30; x2 -> p1_round twice, p1_score 1 then 2, p1_game=1,
//   p2_score=0.
// 2 p1=0x00, p2=0xFF -> p2_round, p2_score=1 (unsigned compare at boundaries).
// 3 Tie 0x42/0x42: TIE_MODE=0 -> tie_round 1 cycle, scores unchanged, back to p1_turn;
//   TIE_MODE=1 -> p1_score=1.
// 4 TIMEOUT_CYC=16: p1 enters, p2 silent 16 cycles -> timeout pulse, p1_round, p1_score=1.
//   Also: p2 press in the expiry cycle -> no timeout, normal compare.
// 5 p1 and p2 asserted in the same cycle during p1_turn -> only p1_lat updates, state -> p2_turn.
//   mid during turns is ignored.
// 6 Score 1:0, reset_n low during p2_turn -> idle=1 asynchronously, scores 0.
//   After a game: mid -> clear_st, scores 0; mid -> idle.

Source files
------------

// File: rtl/match_fsm_pkg.sv
// Shared state encodings, tie-policy constants and small elaboration helpers
// for the two-player match controller.
package match_fsm_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_P1_ENT  = 4'd1,
    S_P2_ENT  = 4'd2,
    S_CMP     = 4'd3,
    S_P1_RND  = 4'd4,
    S_P2_RND  = 4'd5,
    S_TIE_RND = 4'd6,
    S_P1_GAME = 4'd7,
    S_P2_GAME = 4'd8,
    S_CLEAR   = 4'd9
  } state_t;

  localparam int TIE_REPLAY = 0;
  localparam int TIE_P1     = 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/match_fsm_game_timer.sv
// Loadable down-counter with a zero flag; shared by the round-hold and the
// entry-timeout countdowns, which are never active at the same time.
module match_fsm_game_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/match_fsm.sv
// Two-player "higher number wins" match controller with internal scoring,
// deterministic tie handling, per-turn entry timeout and round-result hold.
module match_fsm
  import match_fsm_pkg::*;
#(
  parameter int NUM_W       = 8,
  parameter int WIN_ROUNDS  = 2,
  parameter int TIE_MODE    = 0,
  parameter int TIMEOUT_CYC = 0,
  parameter int HOLD_CYC    = 1,
  localparam int SCW        = $clog2(WIN_ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mid,
  input  logic             p1,
  input  logic             p2,
  input  logic [NUM_W-1:0] p1_num,
  input  logic [NUM_W-1:0] p2_num,
  output logic             idle,
  output logic             p1_turn,
  output logic             p2_turn,
  output logic             p1_round,
  output logic             p2_round,
  output logic             tie_round,
  output logic             p1_game,
  output logic             p2_game,
  output logic             clear_st,
  output logic             timeout,
  output logic [SCW-1:0]   p1_score,
  output logic [SCW-1:0]   p2_score,
  output logic [NUM_W-1:0] p1_lat,
  output logic [NUM_W-1:0] p2_lat
);

  localparam int TMR_MAX = max2(TIMEOUT_CYC, HOLD_CYC);
  localparam int TW      = (TMR_MAX < 1) ? 1 : $clog2(TMR_MAX + 1);
  localparam bit TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [TW-1:0]  HOLD_LD = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0]  TO_LD   = TO_EN ? TW'(TIMEOUT_CYC - 1) : '0;
  localparam logic [SCW-1:0] WIN     = SCW'(WIN_ROUNDS);

  state_t        state_reg, state_next;
  logic          p1_win, p2_win, lat1_ld, lat2_ld, to_fire;
  logic          tmr_zero, tmr_load;
  logic [TW-1:0] tmr_val;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    p1_win     = 1'b0;
    p2_win     = 1'b0;
    lat1_ld    = 1'b0;
    lat2_ld    = 1'b0;
    to_fire    = 1'b0;
    case (state_reg)
      S_IDLE:   if (mid) state_next = S_P1_ENT;
      // A press in the expiry cycle takes priority over the forfeit.
      S_P1_ENT: begin
        if (p1) begin
          lat1_ld    = 1'b1;
          state_next = S_P2_ENT;
        end else if (TO_EN && tmr_zero) begin
          to_fire    = 1'b1;
          p2_win     = 1'b1;
          state_next = S_P2_RND;
        end
      end
      S_P2_ENT: begin
        if (p2) begin
          lat2_ld    = 1'b1;
          state_next = S_CMP;
        end else if (TO_EN && tmr_zero) begin
          to_fire    = 1'b1;
          p1_win     = 1'b1;
          state_next = S_P1_RND;
        end
      end
      S_CMP: begin
        if (p1_lat > p2_lat) begin
          p1_win     = 1'b1;
          state_next = S_P1_RND;
        end else if (p1_lat < p2_lat) begin
          p2_win     = 1'b1;
          state_next = S_P2_RND;
        end else if (TIE_MODE == TIE_P1) begin
          p1_win     = 1'b1;
          state_next = S_P1_RND;
        end else begin
          state_next = S_TIE_RND;
        end
      end
      S_P1_RND:  if (tmr_zero) state_next = (p1_score == WIN) ? S_P1_GAME : S_P1_ENT;
      S_P2_RND:  if (tmr_zero) state_next = (p2_score == WIN) ? S_P2_GAME : S_P1_ENT;
      S_TIE_RND: if (tmr_zero) state_next = S_P1_ENT;
      S_P1_GAME, S_P2_GAME: if (mid) state_next = S_CLEAR;
      S_CLEAR:   if (mid) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Reload on every state change; entry states get the timeout, others the hold.
  assign tmr_load = (state_next != state_reg);
  assign tmr_val  = (state_next == S_P1_ENT || state_next == S_P2_ENT) ? TO_LD : HOLD_LD;

  match_fsm_game_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_score <= '0;
      p2_score <= '0;
      p1_lat   <= '0;
      p2_lat   <= '0;
    end else if (state_next == S_CLEAR && state_reg != S_CLEAR) begin
      p1_score <= '0;
      p2_score <= '0;
      p1_lat   <= '0;
      p2_lat   <= '0;
    end else begin
      if (p1_win && p1_score != WIN) p1_score <= p1_score + 1'b1;
      if (p2_win && p2_score != WIN) p2_score <= p2_score + 1'b1;
      if (lat1_ld) p1_lat <= p1_num;
      if (lat2_ld) p2_lat <= p2_num;
    end
  end

  // Flags are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle      <= 1'b1;
      p1_turn   <= 1'b0;
      p2_turn   <= 1'b0;
      p1_round  <= 1'b0;
      p2_round  <= 1'b0;
      tie_round <= 1'b0;
      p1_game   <= 1'b0;
      p2_game   <= 1'b0;
      clear_st  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      idle      <= (state_next == S_IDLE);
      p1_turn   <= (state_next == S_P1_ENT);
      p2_turn   <= (state_next == S_P2_ENT);
      p1_round  <= (state_next == S_P1_RND);
      p2_round  <= (state_next == S_P2_RND);
      tie_round <= (state_next == S_TIE_RND);
      p1_game   <= (state_next == S_P1_GAME);
      p2_game   <= (state_next == S_P2_GAME);
      clear_st  <= (state_next == S_CLEAR);
      timeout   <= to_fire;
    end
  end

endmodule

// File: tb/tb_match_fsm.sv
// Directed bench for match_fsm: default build, tie-to-P1 build and a
// 16-cycle-timeout / 2-cycle-hold build driven from shared stimulus.
module tb_match_fsm;

  localparam logic [9:0] F_IDLE = 10'h200, F_P1T = 10'h100, F_P2T = 10'h080,
                         F_P1R  = 10'h040, F_P2R = 10'h020, F_TIE = 10'h010,
                         F_P1G  = 10'h008, F_P2G = 10'h004, F_CLR = 10'h002,
                         F_TO   = 10'h001, F_NONE = 10'h000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mid = 1'b0, p1 = 1'b0, p2 = 1'b0;
  logic [7:0] p1_num = 8'h00, p2_num = 8'h00;

  logic       a_idle, a_p1t, a_p2t, a_p1r, a_p2r, a_tie, a_p1g, a_p2g, a_clr, a_to;
  logic       b_idle, b_p1t, b_p2t, b_p1r, b_p2r, b_tie, b_p1g, b_p2g, b_clr, b_to;
  logic       c_idle, c_p1t, c_p2t, c_p1r, c_p2r, c_tie, c_p1g, c_p2g, c_clr, c_to;
  logic [1:0] a_s1, a_s2, b_s1, b_s2, c_s1, c_s2;
  logic [7:0] a_l1, a_l2, b_l1, b_l2, c_l1, c_l2;
  logic [9:0] fa, fb, fc;

  int checks = 0;
  int errors = 0;

  assign fa = {a_idle, a_p1t, a_p2t, a_p1r, a_p2r, a_tie, a_p1g, a_p2g, a_clr, a_to};
  assign fb = {b_idle, b_p1t, b_p2t, b_p1r, b_p2r, b_tie, b_p1g, b_p2g, b_clr, b_to};
  assign fc = {c_idle, c_p1t, c_p2t, c_p1r, c_p2r, c_tie, c_p1g, c_p2g, c_clr, c_to};

  always #5 clk = ~clk;

  match_fsm u_a (
    .clk(clk), .reset_n(reset_n), .mid(mid), .p1(p1), .p2(p2), .p1_num(p1_num), .p2_num(p2_num),
    .idle(a_idle), .p1_turn(a_p1t), .p2_turn(a_p2t), .p1_round(a_p1r), .p2_round(a_p2r),
    .tie_round(a_tie), .p1_game(a_p1g), .p2_game(a_p2g), .clear_st(a_clr), .timeout(a_to),
    .p1_score(a_s1), .p2_score(a_s2), .p1_lat(a_l1), .p2_lat(a_l2));

  match_fsm #(.TIE_MODE(1)) u_b (
    .clk(clk), .reset_n(reset_n), .mid(mid), .p1(p1), .p2(p2), .p1_num(p1_num), .p2_num(p2_num),
    .idle(b_idle), .p1_turn(b_p1t), .p2_turn(b_p2t), .p1_round(b_p1r), .p2_round(b_p2r),
    .tie_round(b_tie), .p1_game(b_p1g), .p2_game(b_p2g), .clear_st(b_clr), .timeout(b_to),
    .p1_score(b_s1), .p2_score(b_s2), .p1_lat(b_l1), .p2_lat(b_l2));

  match_fsm #(.TIMEOUT_CYC(16), .HOLD_CYC(2)) u_c (
    .clk(clk), .reset_n(reset_n), .mid(mid), .p1(p1), .p2(p2), .p1_num(p1_num), .p2_num(p2_num),
    .idle(c_idle), .p1_turn(c_p1t), .p2_turn(c_p2t), .p1_round(c_p1r), .p2_round(c_p2r),
    .tie_round(c_tie), .p1_game(c_p1g), .p2_game(c_p2g), .clear_st(c_clr), .timeout(c_to),
    .p1_score(c_s1), .p2_score(c_s2), .p1_lat(c_l1), .p2_lat(c_l2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_mid();
    mid = 1'b1; tick(); mid = 1'b0;
  endtask

  task automatic pulse_p1(input logic [7:0] n);
    p1_num = n; p1 = 1'b1; tick(); p1 = 1'b0;
  endtask

  task automatic pulse_p2(input logic [7:0] n);
    p2_num = n; p2 = 1'b1; tick(); p2 = 1'b0;
  endtask

  task automatic do_reset();
    mid = 1'b0; p1 = 1'b0; p2 = 1'b0;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (fa !== F_IDLE) begin errors++; $display("FAIL reset_flags got %h expected %h", fa, F_IDLE); end
    checks++; if (fc !== F_IDLE) begin errors++; $display("FAIL reset_flags_c got %h expected %h", fc, F_IDLE); end
    checks++; if ({a_s1, a_s2, a_l1, a_l2} !== 20'h0) begin errors++; $display("FAIL reset_regs got %h expected 0", {a_s1, a_s2, a_l1, a_l2}); end
    $display("reset: flags=%h", fa);
  endtask

  task automatic test_default_match();
    do_reset();
    pulse_mid();
    checks++; if (fa !== F_P1T) begin errors++; $display("FAIL m_p1turn got %h expected %h", fa, F_P1T); end
    pulse_p1(8'h50);
    checks++; if (fa !== F_P2T || a_l1 !== 8'h50) begin errors++; $display("FAIL m_p2turn got %h/%h expected %h/50", fa, a_l1, F_P2T); end
    pulse_p2(8'h30);
    checks++; if (fa !== F_NONE) begin errors++; $display("FAIL m_cmp_latency got %h expected %h", fa, F_NONE); end
    tick();
    checks++; if (fa !== F_P1R || a_s1 !== 2'd1) begin errors++; $display("FAIL m_round1 got %h score %0d expected %h score 1", fa, a_s1, F_P1R); end
    tick();
    checks++; if (fa !== F_P1T) begin errors++; $display("FAIL m_hold1 got %h expected %h", fa, F_P1T); end
    pulse_p1(8'h50); pulse_p2(8'h30); tick();
    checks++; if (fa !== F_P1R || a_s1 !== 2'd2) begin errors++; $display("FAIL m_round2 got %h score %0d expected %h score 2", fa, a_s1, F_P1R); end
    tick();
    checks++; if (fa !== F_P1G || a_s2 !== 2'd0 || a_s1 !== 2'd2) begin errors++; $display("FAIL m_game got %h %0d:%0d expected %h 2:0", fa, a_s1, a_s2, F_P1G); end
    pulse_p1(8'h11); tick();
    checks++; if (fa !== F_P1G || a_s1 !== 2'd2) begin errors++; $display("FAIL m_game_frozen got %h score %0d expected %h score 2", fa, a_s1, F_P1G); end
    pulse_mid();
    checks++; if (fa !== F_CLR || {a_s1, a_s2, a_l1, a_l2} !== 20'h0) begin errors++; $display("FAIL m_clear got %h regs %h expected %h regs 0", fa, {a_s1, a_s2, a_l1, a_l2}, F_CLR); end
    pulse_mid();
    checks++; if (fa !== F_IDLE) begin errors++; $display("FAIL m_idle got %h expected %h", fa, F_IDLE); end
    $display("match: p1 0x50 vs p2 0x30 twice, p1 wins game");
  endtask

  task automatic test_boundary();
    do_reset();
    pulse_mid(); pulse_p1(8'h00); pulse_p2(8'hFF); tick();
    checks++; if (fa !== F_P2R || a_s2 !== 2'd1 || a_s1 !== 2'd0) begin errors++; $display("FAIL bnd_p2win got %h %0d:%0d expected %h 0:1", fa, a_s1, a_s2, F_P2R); end
    checks++; if (a_l1 !== 8'h00 || a_l2 !== 8'hFF) begin errors++; $display("FAIL bnd_latch got %h/%h expected 00/ff", a_l1, a_l2); end
    $display("boundary: p1 0x00 vs p2 0xFF");
  endtask

  task automatic test_tie();
    do_reset();
    pulse_mid(); pulse_p1(8'h42); pulse_p2(8'h42); tick();
    checks++; if (fa !== F_TIE || a_s1 !== 2'd0 || a_s2 !== 2'd0) begin errors++; $display("FAIL tie_replay got %h %0d:%0d expected %h 0:0", fa, a_s1, a_s2, F_TIE); end
    checks++; if (fb !== F_P1R || b_s1 !== 2'd1) begin errors++; $display("FAIL tie_p1 got %h score %0d expected %h score 1", fb, b_s1, F_P1R); end
    tick();
    checks++; if (fa !== F_P1T || fb !== F_P1T) begin errors++; $display("FAIL tie_back got %h/%h expected %h", fa, fb, F_P1T); end
    $display("tie: 0x42 vs 0x42");
  endtask

  task automatic test_timeout();
    do_reset();
    pulse_mid(); pulse_p1(8'h50);
    repeat (15) tick();
    checks++; if (fc !== F_P2T) begin errors++; $display("FAIL to_before got %h expected %h", fc, F_P2T); end
    tick();
    checks++; if (fc !== (F_P1R | F_TO) || c_s1 !== 2'd1 || c_l2 !== 8'h00) begin errors++; $display("FAIL to_fire got %h score %0d lat %h expected %h score 1 lat 00", fc, c_s1, c_l2, F_P1R | F_TO); end
    tick();
    checks++; if (fc !== F_P1R) begin errors++; $display("FAIL to_hold got %h expected %h", fc, F_P1R); end
    tick();
    checks++; if (fc !== F_P1T) begin errors++; $display("FAIL to_after_hold got %h expected %h", fc, F_P1T); end
    // press exactly in the expiry cycle
    do_reset();
    pulse_mid(); pulse_p1(8'h50);
    repeat (15) tick();
    pulse_p2(8'h10);
    checks++; if (fc !== F_NONE) begin errors++; $display("FAIL to_press_wins got %h expected %h", fc, F_NONE); end
    tick();
    checks++; if (fc !== F_P1R || c_s1 !== 2'd1 || c_l2 !== 8'h10) begin errors++; $display("FAIL to_press_cmp got %h score %0d lat %h expected %h score 1 lat 10", fc, c_s1, c_l2, F_P1R); end
    // P1 silent forfeits to P2
    do_reset();
    pulse_mid();
    repeat (15) tick();
    checks++; if (fc !== F_P1T) begin errors++; $display("FAIL to_p1_before got %h expected %h", fc, F_P1T); end
    tick();
    checks++; if (fc !== (F_P2R | F_TO) || c_s2 !== 2'd1) begin errors++; $display("FAIL to_p1_fire got %h score %0d expected %h score 1", fc, c_s2, F_P2R | F_TO); end
    $display("timeout: 16-cycle expiry, press-in-expiry, p1 forfeit");
  endtask

  task automatic test_simultaneous();
    do_reset();
    pulse_mid(); pulse_mid();
    checks++; if (fa !== F_P1T) begin errors++; $display("FAIL sim_mid_p1 got %h expected %h", fa, F_P1T); end
    p1_num = 8'h11; p2_num = 8'h22; p1 = 1'b1; p2 = 1'b1; tick(); p1 = 1'b0; p2 = 1'b0;
    checks++; if (fa !== F_P2T || a_l1 !== 8'h11 || a_l2 !== 8'h00) begin errors++; $display("FAIL sim_both got %h lat %h/%h expected %h lat 11/00", fa, a_l1, a_l2, F_P2T); end
    pulse_mid(); pulse_p1(8'h33);
    checks++; if (fa !== F_P2T || a_l1 !== 8'h11) begin errors++; $display("FAIL sim_ignore got %h lat %h expected %h lat 11", fa, a_l1, F_P2T); end
    $display("simultaneous: p1+p2 in p1_turn, mid/p1 ignored in p2_turn");
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse_mid(); pulse_p1(8'h50); pulse_p2(8'h30); tick(); tick();
    pulse_p1(8'h60);
    checks++; if (fa !== F_P2T || a_s1 !== 2'd1) begin errors++; $display("FAIL ar_setup got %h score %0d expected %h score 1", fa, a_s1, F_P2T); end
    reset_n = 1'b0;
    #1;
    checks++; if (fa !== F_IDLE || a_s1 !== 2'd0 || a_l1 !== 8'h00) begin errors++; $display("FAIL ar_async got %h score %0d lat %h expected %h score 0 lat 00", fa, a_s1, a_l1, F_IDLE); end
    tick();
    reset_n = 1'b1;
    $display("async reset during p2_turn at score 1:0");
  endtask

  initial begin
    test_reset();
    test_default_match();
    test_boundary();
    test_tie();
    test_timeout();
    test_simultaneous();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
